pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl_if.sv | 27 ++
 rtl/pwm_ramp_ctrl.sv | 115 +++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ramp_ctrl_if.sv
// Bundles the control side of pwm_ramp_ctrl: tick, target handshake, abort,
// and the duty/status outputs. The master drives targets; the slave is the
// ramp controller. The state signal exposes the controller FSM for checkers.
interface pwm_ramp_ctrl_if #(
  parameter int RES = 8
);
  logic           period_tick;
  logic           tgt_valid;
  logic [RES:0]   tgt_duty;
  logic [RES-1:0] step;
  logic           abort;
  logic           tgt_ready;
  logic [RES:0]   duty;
  logic           busy;
  logic           done;
  logic [0:0]     state;

  modport master (
    output period_tick, tgt_valid, tgt_duty, step, abort,
    input  tgt_ready, duty, busy, done, state
  );

  modport slave (
    input  period_tick, tgt_valid, tgt_duty, step, abort,
    output tgt_ready, duty, busy, done, state
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller. Accepts a target duty and a step size, then walks
// the registered duty toward the target by one step every HOLD PWM periods,
// clamping at the target. Abort freezes the duty where it is.
//
// Handshake: a target is taken on a rising clk edge where tgt_valid and
// tgt_ready are both 1. tgt_ready is high only in IDLE; offers made while a
// ramp is running are dropped, not queued, and the master must re-offer.
module pwm_ramp_ctrl #(
  parameter int RES  = 8,
  parameter int HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  pwm_ramp_ctrl_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

  // Hold counter must count 0..HOLD-1; keep at least one bit for HOLD=1.
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  // Two extra bits so duty+step and tgt+step comparisons cannot wrap.
  localparam int AW = RES + 2;

  localparam logic [RES:0]  FULL      = {1'b1, {RES{1'b0}}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  logic [0:0]     state;
  logic [RES:0]   duty_q;
  logic [RES:0]   tgt_q;
  logic [RES-1:0] step_q;
  logic [HW-1:0]  hold_q;
  logic           done_q;

  logic           accept;
  logic [RES:0]   sat_tgt;
  logic [RES-1:0] eff_step;
  logic           up;
  logic [AW-1:0]  sum_e;
  logic [AW-1:0]  lim_e;
  logic [RES:0]   next_duty;

  // Accept qualification and the saturated / non-zero values latched on accept.
  always_comb begin
    accept   = (state == IDLE) && bus.tgt_valid;
    sat_tgt  = (bus.tgt_duty > FULL) ? FULL : bus.tgt_duty;
    eff_step = (bus.step == '0) ? RES'(1) : bus.step;
  end

  // Next duty for one ramp step, clamped at the target in either direction.
  // The narrow add/subtract is only used when the wide compare shows no clamp,
  // so it cannot wrap.
  always_comb begin
    up    = tgt_q > duty_q;
    sum_e = AW'(duty_q) + AW'(step_q);
    lim_e = AW'(tgt_q) + AW'(step_q);
    if (up) begin
      next_duty = (sum_e >= AW'(tgt_q)) ? tgt_q : duty_q + (RES+1)'(step_q);
    end else begin
      next_duty = (AW'(duty_q) <= lim_e) ? tgt_q : duty_q - (RES+1)'(step_q);
    end
  end

  // FSM, hold counter, duty register and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      duty_q <= '0;
      tgt_q  <= '0;
      step_q <= '0;
      hold_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          tgt_q  <= sat_tgt;
          step_q <= eff_step;
          hold_q <= '0;
          if (sat_tgt == duty_q) begin
            done_q <= 1'b1;
          end else begin
            state <= RAMP;
          end
        end
      end else begin
        if (bus.abort) begin
          state  <= IDLE;
          hold_q <= '0;
        end else if (bus.period_tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_q <= '0;
            duty_q <= next_duty;
            if (next_duty == tgt_q) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
      end
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    bus.tgt_ready = (state == IDLE);
    bus.busy      = (state == RAMP);
    bus.duty      = duty_q;
    bus.done      = done_q;
    bus.state     = state;
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramp scenarios followed by a random phase,
// all checked every cycle against a plain-arithmetic model of the ramp rules.
module tb_pwm_ramp_ctrl;
  localparam int RES  = 8;
  localparam int HOLD = 2;
  localparam int FULL = 256;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_ramp_ctrl_if #(.RES(RES)) bus ();

  pwm_ramp_ctrl #(.RES(RES), .HOLD(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int phase = 0;

  // reference model state
  int m_duty, m_tgt, m_step, m_ticks;
  bit m_busy, m_done;

  // observation log
  logic [RES:0] exp_q[$];
  logic [RES:0] chg_q[$];
  logic [RES:0] last_duty;
  int           max_duty;
  int           done_cnt;
  int           done_duty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_tgt = 0; m_step = 1; m_ticks = 0; m_busy = 0; m_done = 0;
  endtask

  // Applies the ramp rules to the inputs present at the coming clock edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      if (bus.tgt_valid) begin
        m_tgt  = (int'(bus.tgt_duty) > FULL) ? FULL : int'(bus.tgt_duty);
        m_step = (bus.step == 0) ? 1 : int'(bus.step);
        if (m_tgt == m_duty) m_done = 1;
        else begin
          m_busy  = 1;
          m_ticks = 0;
        end
      end
    end else if (bus.abort) begin
      m_busy = 0;
    end else if (bus.period_tick) begin
      m_ticks++;
      if (m_ticks == HOLD) begin
        m_ticks = 0;
        if (m_tgt > m_duty) m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
        else                m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
        if (m_duty == m_tgt) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // driver: one clock with period_tick every 10th cycle, then compare
  task automatic step_clk();
    bus.period_tick = (phase == 9);
    model_edge();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 10;
    chk("duty",  32'(bus.duty),      32'(m_duty));
    chk("busy",  32'(bus.busy),      32'(m_busy));
    chk("ready", 32'(bus.tgt_ready), 32'(!m_busy));
    chk("done",  32'(bus.done),      32'(m_done));
    if (bus.duty !== last_duty) chg_q.push_back(bus.duty);
    last_duty = bus.duty;
    if (int'(bus.duty) > max_duty) max_duty = int'(bus.duty);
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_duty = int'(bus.duty);
    end
  endtask

  task automatic clear_log();
    chg_q.delete();
    exp_q.delete();
    max_duty  = 0;
    done_cnt  = 0;
    done_duty = -1;
  endtask

  task automatic offer(input int tgt, input int stp);
    bus.tgt_valid = 1'b1;
    bus.tgt_duty  = (RES+1)'(tgt);
    bus.step      = RES'(stp);
    step_clk();
    bus.tgt_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      step_clk();
      n++;
    end
    chk("ramp_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic run_until_duty(input int d, input int budget);
    int n = 0;
    while (m_duty != d && n < budget) begin
      step_clk();
      n++;
    end
    chk("duty_wait_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic compare_changes(input string tag);
    chk({tag, "_count"}, 32'(chg_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < chg_q.size(); i++)
      chk({tag, "_value"}, 32'(chg_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk();
    step_clk();
    rst = 1'b0;
  endtask

  initial begin
    bus.period_tick = 1'b0;
    bus.tgt_valid   = 1'b0;
    bus.tgt_duty    = '0;
    bus.step        = '0;
    bus.abort       = 1'b0;
    last_duty       = '0;
    model_reset();
    clear_log();

    // reset state
    do_reset();
    chk("rst_duty",  32'(bus.duty),      32'd0);
    chk("rst_ready", 32'(bus.tgt_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);

    // up-ramp 0 -> 100, step 30
    clear_log();
    offer(100, 30);
    chk("up_busy_after_accept", 32'(bus.busy), 32'd1);
    run_until_idle(400);
    exp_q = '{9'd30, 9'd60, 9'd90, 9'd100};
    compare_changes("up_seq");
    chk("up_done_count", 32'(done_cnt), 32'd1);
    chk("up_done_duty",  32'(done_duty), 32'd100);

    // down-ramp 100 -> 10, step 40, with an ignored mid-ramp offer
    clear_log();
    offer(10, 40);
    repeat (5) step_clk();
    chk("down_ready_mid", 32'(bus.tgt_ready), 32'd0);
    offer(200, 1);
    repeat (3) step_clk();
    run_until_idle(400);
    exp_q = '{9'd60, 9'd20, 9'd10};
    compare_changes("down_seq");
    chk("down_final", 32'(bus.duty), 32'd10);
    chk("down_done_count", 32'(done_cnt), 32'd1);

    // saturation and zero step: 10 -> 256 by 1
    clear_log();
    offer(300, 0);
    run_until_idle(6000);
    chk("sat_final",   32'(bus.duty),    32'd256);
    chk("sat_max",     32'(max_duty),    32'd256);
    chk("sat_changes", 32'(chg_q.size()), 32'd246);
    if (chg_q.size() > 0) chk("sat_first", 32'(chg_q[0]), 32'd11);

    // abort on the same cycle as a qualifying tick
    do_reset();
    clear_log();
    offer(100, 30);
    run_until_duty(60, 400);
    begin
      int n = 0;
      while (!(phase == 9 && m_ticks == HOLD - 1) && n < 100) begin
        step_clk();
        n++;
      end
      chk("abort_align_timeout", 32'(n < 100), 32'd1);
    end
    bus.abort = 1'b1;
    step_clk();
    bus.abort = 1'b0;
    chk("abort_duty",  32'(bus.duty),      32'd60);
    chk("abort_busy",  32'(bus.busy),      32'd0);
    chk("abort_ready", 32'(bus.tgt_ready), 32'd1);
    chk("abort_state", 32'(bus.state),     32'd0);
    repeat (30) step_clk();
    chk("abort_hold_duty", 32'(bus.duty), 32'd60);
    chk("abort_no_done",   32'(done_cnt), 32'd0);

    // equal target
    offer(60, 5);
    chk("eq_done",  32'(bus.done), 32'd1);
    chk("eq_busy",  32'(bus.busy), 32'd0);
    chk("eq_duty",  32'(bus.duty), 32'd60);
    step_clk();
    chk("eq_done_clear", 32'(bus.done), 32'd0);

    // asynchronous reset mid-ramp at duty 90
    offer(100, 30);
    run_until_duty(90, 400);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_duty",  32'(bus.duty),      32'd0);
    chk("arst_busy",  32'(bus.busy),      32'd0);
    chk("arst_done",  32'(bus.done),      32'd0);
    chk("arst_ready", 32'(bus.tgt_ready), 32'd1);
    model_reset();
    step_clk();
    rst = 1'b0;
    offer(50, 10);
    chk("arst_accept_busy", 32'(bus.busy), 32'd1);
    run_until_idle(400);
    chk("arst_final", 32'(bus.duty), 32'd50);

    // random phase against the model
    for (int c = 0; c < 3000; c++) begin
      bus.tgt_valid = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) bus.tgt_duty = (RES+1)'(m_duty);
      else                           bus.tgt_duty = (RES+1)'($urandom_range(0, 300));
      if ($urandom_range(0, 3) == 0) bus.step = RES'($urandom_range(0, 255));
      else                           bus.step = RES'($urandom_range(0, 40));
      bus.abort = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step_clk();
    end
    rst = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.abort = 1'b0;
    step_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
